// File: rtl/pipe_dffs.sv
// pipe_dffs: DEPTH-stage, WIDTH-bit elastic register chain with per-stage
// valid bits, valid/ready backpressure, bubble collapsing, synchronous flush
// and a registered occupancy count. Stage 0 is the input side, stage
// DEPTH-1 drives data_o/valid_o.
module pipe_dffs #(
    parameter int unsigned           WIDTH     = 32,
    parameter int unsigned           DEPTH     = 2,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         valid_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic                         ready_o,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             data_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             in_xfer;
    logic             out_xfer;
    logic [CW-1:0]    count;

    // Handshake qualification; flush masks both sides so nothing transfers
    assign ready_o  = adv[0] & ~flush_i;
    assign in_xfer  = valid_i & ready_o;
    assign valid_o  = valid[DEPTH-1] & ~flush_i;
    assign out_xfer = valid_o & ready_i;
    assign data_o   = data[DEPTH-1];
    assign count_o  = count;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            logic             src_valid;
            logic [WIDTH-1:0] src_data;

            // Stage k may advance when it is empty, when any stage nearer the
            // output is empty, or when the consumer is taking data. This is
            // the unrolled form of adv[k] = ~valid[k] | adv[k+1].
            assign adv[k] = ready_i | ~(&valid[DEPTH-1:k]);

            if (k == 0) begin : g_head
                assign src_valid = in_xfer;
                assign src_data  = data_i;
            end else begin : g_body
                assign src_valid = valid[k-1];
                assign src_data  = data[k-1];
            end

            // Stage register: take upstream on advance, load data only from a valid source
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    valid[k] <= 1'b0;
                    data[k]  <= RESET_VAL;
                end else if (flush_i) begin
                    valid[k] <= 1'b0;
                end else if (adv[k]) begin
                    valid[k] <= src_valid;
                    if (src_valid) begin
                        data[k] <= src_data;
                    end
                end
            end
        end
    endgenerate

    // Occupancy: +1 per input transfer, -1 per output transfer, cleared by flush
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (flush_i) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_dffs.sv
// Bench for pipe_dffs: directed scenarios plus random traffic, checked every
// cycle against an item-level model (queue of items with chain positions).
module tb_pipe_dffs;

    localparam int W = 5;
    localparam int D = 4;
    localparam logic [W-1:0] RV = 5'b00000;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         valid_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         ready_i = 1'b0;
    logic         ready_o;
    logic         valid_o;
    logic [W-1:0] data_o;
    logic [2:0]   count_o;

    pipe_dffs #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i),
        .count_o (count_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ordered items, each with its chain position (0..D-1).
    typedef struct {
        logic [W-1:0] data;
        int           pos;
    } item_t;

    item_t        q[$];
    logic [W-1:0] last_data = RV;

    function automatic void model_step();
        bit    acc;
        bit    pop;
        int    n;
        int    prev;
        item_t it;
        n   = q.size();
        acc = valid_i && !flush_i && (n < D || ready_i);
        pop = !flush_i && n > 0 && q[0].pos == D - 1 && ready_i;
        if (flush_i) begin
            q.delete();
        end else begin
            if (pop) it = q.pop_front();
            prev = D;
            for (int j = 0; j < q.size(); j++) begin
                it = q[j];
                it.pos = (it.pos + 1 < prev - 1) ? it.pos + 1 : prev - 1;
                q[j] = it;
                prev = it.pos;
            end
            if (acc) begin
                it.data = data_i;
                it.pos  = 0;
                q.push_back(it);
            end
            if (q.size() > 0 && q[0].pos == D - 1) last_data = q[0].data;
        end
    endfunction

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            q.delete();
            last_data = RV;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic exp_v;
        logic exp_r;
        exp_v = rst_i && !flush_i && q.size() > 0 && q[0].pos == D - 1;
        exp_r = !flush_i && (q.size() < D || ready_i);
        chk("valid_o", 32'(valid_o), 32'(exp_v));
        chk("ready_o", 32'(ready_o), 32'(exp_r));
        chk("data_o", 32'(data_o), 32'(last_data));
        chk("count_o", 32'(count_o), 32'(q.size()));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

    initial begin
        // Reset
        step();
        step();
        rst_i = 1'b1;
        #1;
        chk("rst valid_o", 32'(valid_o), 32'd0);
        chk("rst data_o", 32'(data_o), 32'd0);
        chk("rst count_o", 32'(count_o), 32'd0);
        chk("rst ready_o", 32'(ready_o), 32'd1);

        // Streaming 0..9
        ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            valid_i = 1'b1;
            data_i  = W'(i);
            step();
            if (i == 2) chk("stream early valid_o", 32'(valid_o), 32'd0);
            if (i == 3) begin
                chk("stream first valid_o", 32'(valid_o), 32'd1);
                chk("stream first data_o", 32'(data_o), 32'd0);
                chk("stream full count_o", 32'(count_o), 32'd4);
            end
        end
        valid_i = 1'b0;
        repeat (6) step();
        chk("stream drained count_o", 32'(count_o), 32'd0);

        // Backpressure 1..5
        ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            valid_i = 1'b1;
            data_i  = W'(i);
            #1;
            if (i == 5) chk("bp ready_o full", 32'(ready_o), 32'd0);
            step();
        end
        chk("bp count_o", 32'(count_o), 32'd4);
        ready_i = 1'b1;
        #1;
        chk("bp head data_o", 32'(data_o), 32'd1);
        chk("bp full ready_o", 32'(ready_o), 32'd1);
        step();
        valid_i = 1'b0;
        repeat (6) step();

        // Bubble collapse
        ready_i = 1'b0;
        valid_i = 1'b1; data_i = 5'd7;
        step();
        valid_i = 1'b0;
        step();
        step();
        valid_i = 1'b1; data_i = 5'd9;
        step();
        valid_i = 1'b0;
        step();
        step();
        chk("bubble count_o", 32'(count_o), 32'd2);
        chk("bubble head data_o", 32'(data_o), 32'd7);
        ready_i = 1'b1;
        step();
        chk("bubble second valid_o", 32'(valid_o), 32'd1);
        chk("bubble second data_o", 32'(data_o), 32'd9);
        repeat (4) step();

        // Flush
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            data_i  = W'(10 + i);
            step();
        end
        chk("flush fill count_o", 32'(count_o), 32'd4);
        flush_i = 1'b1; valid_i = 1'b1; data_i = 5'd21; ready_i = 1'b1;
        #1;
        chk("flush valid_o", 32'(valid_o), 32'd0);
        chk("flush ready_o", 32'(ready_o), 32'd0);
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        chk("post flush count_o", 32'(count_o), 32'd0);
        chk("post flush valid_o", 32'(valid_o), 32'd0);
        chk("post flush data kept", 32'(data_o), 32'd10);
        repeat (2) step();

        // Async reset mid-stream
        ready_i = 1'b0;
        for (int i = 3; i < 6; i++) begin
            valid_i = 1'b1;
            data_i  = W'(i);
            step();
        end
        valid_i = 1'b0;
        chk("pre reset count_o", 32'(count_o), 32'd3);
        #2;
        rst_i = 1'b0;
        #1;
        chk("async rst valid_o", 32'(valid_o), 32'd0);
        chk("async rst count_o", 32'(count_o), 32'd0);
        chk("async rst data_o", 32'(data_o), 32'd0);
        step();
        rst_i = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            valid_i = 1'b1;
            data_i  = W'(20 + i);
            step();
            if (i == 2) chk("restart early valid_o", 32'(valid_o), 32'd0);
            if (i == 3) chk("restart first data_o", 32'(data_o), 32'd20);
        end
        valid_i = 1'b0;
        repeat (6) step();

        // Random traffic: stall-heavy phase then flowing phase
        for (int i = 0; i < 600; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 24) == 0);
            data_i  = W'($urandom);
            step();
        end
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (6) step();
        chk("final count_o", 32'(count_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_dffs.md
Name: pipe_dffs

Overview:
- Parametrised successor to the plain DFF register bank: a DEPTH-stage, WIDTH-bit elastic pipeline register chain.
- Each stage carries a valid bit, so the chain supports valid/ready backpressure, bubble collapsing, synchronous flush and an occupancy count.
- Used between CPU pipeline stages and as a generic delay or buffer element wherever a stallable, flushable register chain is needed.

Parameters:
- WIDTH, 32, data width in bits; must be >= 1.
- DEPTH, 2, number of register stages; must be >= 1. Stage 0 is the input side, stage DEPTH-1 is the output side.
- RESET_VAL, 0, WIDTH-bit value loaded into every data register on reset.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous flush; invalidates all stages.
- valid_i  input  1  input data valid.
- data_i  input  WIDTH  input data.
- ready_o  output  1  pipeline can accept data this cycle.
- valid_o  output  1  stage DEPTH-1 holds valid data.
- data_o  output  WIDTH  data register of stage DEPTH-1.
- ready_i  input  1  consumer accepts data_o this cycle.
- count_o  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset: rst_i low clears state immediately, without waiting for a clock edge.
  - All valid bits go to 0, so valid_o=0 and count_o=0.
  - All data registers load RESET_VAL, so data_o=RESET_VAL.
  - ready_o=1 once rst_i is high and flush_i is low.
- Handshakes:
  - Input transfer = valid_i & ready_o.
  - Output transfer = valid_o & ready_i.
  - A transfer occurs on the rising edge at the end of the cycle in which the condition is true.
- Advance rule, combinational, chained from the output side:
  - adv[DEPTH] = ready_i.
  - adv[k] = ~valid[k] | adv[k+1].
  - ready_o = adv[0] & ~flush_i.
- Stage update on each edge:
  - If adv[k+1], stage k+1 takes valid[k] and data[k].
  - Stage 0 takes valid = input transfer and data = data_i when adv[0].
  - A stage whose adv is 0 holds both its valid bit and its data.
  - A data register loads only when its source is valid; otherwise it keeps its old data.
- Bubble collapsing: an empty stage always accepts from upstream even when downstream is stalled. DEPTH items can therefore be held with ready_i=0.
- Latency and throughput:
  - An item accepted at edge N appears on data_o with valid_o=1 after edge N+DEPTH-1 when ready_i=1 throughout, i.e. DEPTH cycles of delay from presentation.
  - Throughput is 1 item per cycle.
- Ordering: strict FIFO; no item is duplicated or dropped except by flush or reset.
- Full and empty:
  - When all stages are valid and ready_i=0, ready_o=0.
  - Full with ready_i=1: simultaneous in and out transfers are allowed (ready_o=1) and count_o holds.
- Flush:
  - flush_i=1 forces ready_o=0 and valid_o=0 combinationally, so no transfer occurs that cycle.
  - On the next edge all valid bits clear and count_o becomes 0; data registers keep their contents.
  - flush_i has priority over every other event.
- count_o is a registered counter:
  - +1 on input transfer, -1 on output transfer, unchanged if both or neither occur.
  - 0 on flush.
  - It never exceeds DEPTH and never underflows.
  - Invariant: it always equals the popcount of the valid bits.
- Reset mid-operation: in-flight items are lost. No output transfer may be reported in the cycle reset asserts.
- DEPTH=1: a single register with ready_o = ~valid_o | ready_i.

Test Plan:
- Reset (WIDTH=5, DEPTH=4, RESET_VAL=5'b00000): hold rst_i=0 for 1 cycle, then release -> valid_o=0, data_o=00000, count_o=0, ready_o=1.
- Streaming: ready_i=1, push data_i=0..9 on consecutive cycles.
  - valid_o first high after the 4th edge; data_o=0,1,...,9 on consecutive cycles.
  - count_o rises 1..4, holds at 4, then drains to 0.
- Backpressure: ready_i=0, attempt pushes 1..5.
  - Items 1..4 accepted; ready_o=0 on the 5th attempt; count_o=4.
  - Then set ready_i=1 -> data_o=1,2,3,4 in order, item 5 accepted, no loss or duplication.
- Bubble collapse: push 7, idle 2 cycles, then push 9 with ready_i=0.
  - 7 reaches stage 3; 9 compacts into stage 2; count_o=2.
  - Release ready_i -> outputs 7 then 9 on consecutive cycles.
- Flush: fill to count_o=4, then assert flush_i for 1 cycle with valid_i=1, data_i=21.
  - valid_o=0 and ready_o=0 during the flush cycle.
  - After the edge, count_o=0 and valid_o=0; 21 never appears on data_o.
- Async reset mid-stream: with count_o=3, drop rst_i mid-cycle -> valid_o=0, count_o=0, data_o=00000 before the next clock edge.
  - After release, streaming restarts with the correct 4-cycle latency.
